stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/stopwatch_ctrl_btn_cond.sv | 76 +++++++
 rtl/stopwatch_ctrl.sv | 138 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencing controller.
//   sw_state_e         : FSM state encoding, exported on the 'state' port
//   TICK_DIV_DEFAULT   : default clk cycles per base tick
//   DEB_CYCLES_DEFAULT : default debounce length (STOPWATCH_DEBOUNCE_EN builds)
//   is_running()       : true in the states where the prescaler advances
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  localparam int unsigned TICK_DIV_DEFAULT   = 1000;
  localparam int unsigned DEB_CYCLES_DEFAULT = 16;

  function automatic logic is_running(input sw_state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_cond.sv
// Button conditioner: 2-FF synchronizer, optional debouncer, rising-edge pulse.
// Build option: STOPWATCH_DEBOUNCE_EN adds a debouncer that accepts a new level
// only after DEB_CYCLES consecutive identical synchronized samples.
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   btn_i    raw button, asynchronous to clk, active-high
//   press_o  one-cycle press event, decoded from registers only
module btn_cond #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 65535) begin : g_bad_deb
    $error("btn_cond: DEB_CYCLES out of range 1..65535");
  end

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic [CW-1:0] deb_cnt_q;
  logic          stable_q;

  // Counts consecutive samples that differ from the accepted level; any sample
  // that agrees restarts the count, so short glitches never get through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt_q <= '0;
      stable_q  <= 1'b0;
    end else if (sync2_q == stable_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == CW'(DEB_CYCLES - 1)) begin
      deb_cnt_q <= '0;
      stable_q  <= sync2_q;
    end else begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  // Only a 0->1 change of the conditioned level is an event, so a held
  // button yields exactly one press.
  assign press_o = level & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: turns start/stop and lap/reset buttons into
// time-counter controls and divides clk into the base tick.
// Build option: STOPWATCH_DEBOUNCE_EN enables button debouncing in btn_cond.
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   btn_ss      raw start/stop button
//   btn_lr      raw lap/reset button
//   tick_en     one-cycle count enable for the time counter
//   cnt_clr     one-cycle synchronous clear for the time counter
//   run         high in RUN or LAP
//   lap_hold    high in LAP (display freezes)
//   lap_strobe  one-cycle pulse on entry to LAP (display captures)
//   state       current FSM state (sw_state_e encoding)
// Handshake: none; button events are single-cycle pulses and every output is
// either a registered pulse or a decode of the registered state.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       tick_en,
  output logic       cnt_clr,
  output logic       run,
  output logic       lap_hold,
  output logic       lap_strobe,
  output logic [1:0] state
);

  if (TICK_DIV < 2 || TICK_DIV > 65535) begin : g_bad_div
    $error("stopwatch_ctrl: TICK_DIV out of range 2..65535");
  end

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic      ss_ev;
  logic      lr_ev;
  sw_state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic      tick_q, tick_d;
  logic      clr_q, clr_d;
  logic      strobe_q, strobe_d;
  logic      keep_running;
  logic      presc_wrap;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_ss (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_ss),
    .press_o (ss_ev)
  );

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_lr (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_lr),
    .press_o (lr_ev)
  );

  // Start/stop is checked first in every state, so a simultaneous lap/reset
  // event is dropped.
  always_comb begin
    state_d  = state_q;
    strobe_d = 1'b0;
    clr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_ev) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ss_ev) begin
          state_d = ST_PAUSE;
        end else if (lr_ev) begin
          state_d  = ST_LAP;
          strobe_d = 1'b1;
        end
      end
      ST_LAP: begin
        if (ss_ev)      state_d = ST_PAUSE;
        else if (lr_ev) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (ss_ev) begin
          state_d = ST_RUN;
        end else if (lr_ev) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The prescaler only advances when running both now and next cycle: the
  // cycle that leaves for PAUSE neither ticks nor moves the phase, and the
  // cycle that enters RUN from PAUSE/IDLE starts from the held phase, which
  // puts the first tick after IDLE exactly TICK_DIV cycles out.
  always_comb begin
    keep_running = is_running(state_q) && is_running(state_d);
    presc_wrap   = (presc_q == PW'(TICK_DIV - 1));
    tick_d       = keep_running && presc_wrap;
    presc_d      = presc_q;
    if (state_d == ST_IDLE) begin
      presc_d = '0;
    end else if (keep_running) begin
      presc_d = presc_wrap ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      tick_q   <= 1'b0;
      clr_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      clr_q    <= clr_d;
      strobe_q <= strobe_d;
    end
  end

  assign tick_en    = tick_q;
  assign cnt_clr    = clr_q;
  assign lap_strobe = strobe_q;
  assign run        = is_running(state_q);
  assign lap_hold   = (state_q == ST_LAP);
  assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEB_CYCLES=5.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int TDIV = 4;
  localparam int DEB  = 5;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;  // edges with old state after press is set
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       reset;
  logic       btn_ss;
  logic       btn_lr;
  logic       tick_en;
  logic       cnt_clr;
  logic       run;
  logic       lap_hold;
  logic       lap_strobe;
  logic [1:0] state;

  int passes = 0;
  int total  = 0;
  int ph     = 0;  // expected prescaler phase

  stopwatch_ctrl #(.TICK_DIV(TDIV), .DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_ss     (btn_ss),
    .btn_lr     (btn_lr),
    .tick_en    (tick_en),
    .cnt_clr    (cnt_clr),
    .run        (run),
    .lap_hold   (lap_hold),
    .lap_strobe (lap_strobe),
    .state      (state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles in RUN/LAP: tick_en expected whenever the phase was TDIV-1.
  task automatic run_cycles(input int n, input logic [1:0] st);
    for (int i = 0; i < n; i++) begin
      step();
      check1("tick_run", tick_en, ph == TDIV - 1);
      ph = (ph + 1) % TDIV;
      check_st("state_run", state, st);
      check1("strobe_quiet", lap_strobe, 1'b0);
      check1("clr_quiet", cnt_clr, 1'b0);
    end
  endtask

  // Cycles in IDLE/PAUSE: no pulses at all, state unchanged.
  task automatic still_cycles(input int n, input logic [1:0] st);
    for (int i = 0; i < n; i++) begin
      step();
      check1("tick_still", tick_en, 1'b0);
      check_st("state_still", state, st);
      check1("strobe_still", lap_strobe, 1'b0);
      check1("clr_still", cnt_clr, 1'b0);
      check1("run_still", run, 1'b0);
    end
  endtask

  initial begin
    reset  = 1'b1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;

    // 1. reset state, then 20 quiet cycles
    step();
    check_st("rst_state", state, ST_IDLE);
    check1("rst_tick", tick_en, 1'b0);
    check1("rst_clr", cnt_clr, 1'b0);
    check1("rst_run", run, 1'b0);
    check1("rst_hold", lap_hold, 1'b0);
    check1("rst_strobe", lap_strobe, 1'b0);
    reset = 1'b0;
    still_cycles(20, ST_IDLE);

`ifdef STOPWATCH_DEBOUNCE_EN
    // 6. glitch shorter than DEB_CYCLES is ignored
    btn_ss = 1'b1;
    still_cycles(3, ST_IDLE);
    btn_ss = 1'b0;
    still_cycles(15, ST_IDLE);
`endif

    // 2. long ss press -> RUN after LAT edges, ticks every TDIV
    btn_ss = 1'b1;
    still_cycles(LAT, ST_IDLE);
    step();
    check_st("enter_run", state, ST_RUN);
    check1("enter_run_run", run, 1'b1);
    check1("enter_run_tick", tick_en, 1'b0);
    ph = 0;
    run_cycles(8, ST_RUN);  // still held: no second event
    btn_ss = 1'b0;
    run_cycles(4, ST_RUN);

    // 3. lap in, ticks continue, lap out
    btn_lr = 1'b1;
    run_cycles(LAT, ST_RUN);
    step();
    check1("lap_tick", tick_en, ph == TDIV - 1);
    ph = (ph + 1) % TDIV;
    check_st("enter_lap", state, ST_LAP);
    check1("lap_strobe_on", lap_strobe, 1'b1);
    check1("lap_hold_on", lap_hold, 1'b1);
    check1("lap_run", run, 1'b1);
    btn_lr = 1'b0;
    run_cycles(LAT + 6, ST_LAP);
    check1("lap_hold_stay", lap_hold, 1'b1);
    btn_lr = 1'b1;
    run_cycles(LAT, ST_LAP);
    step();
    check1("unlap_tick", tick_en, ph == TDIV - 1);
    ph = (ph + 1) % TDIV;
    check_st("leave_lap", state, ST_RUN);
    check1("lap_hold_off", lap_hold, 1'b0);
    check1("unlap_strobe", lap_strobe, 1'b0);
    btn_lr = 1'b0;
    run_cycles(LAT + 3, ST_RUN);

    // 4. pause with phase 2, resume -> tick 2 cycles later
    while ((ph + LAT) % TDIV != 2) run_cycles(1, ST_RUN);
    btn_ss = 1'b1;
    run_cycles(LAT, ST_RUN);
    step();
    check_st("enter_pause", state, ST_PAUSE);
    check1("pause_tick", tick_en, 1'b0);
    btn_ss = 1'b0;
    still_cycles(LAT + 6, ST_PAUSE);
    btn_ss = 1'b1;
    still_cycles(LAT, ST_PAUSE);
    step();
    check_st("resume", state, ST_RUN);
    check1("resume_tick0", tick_en, 1'b0);
    btn_ss = 1'b0;
    step();
    check1("resume_tick1", tick_en, 1'b0);
    step();
    check1("resume_tick2", tick_en, 1'b1);
    ph = 0;
    run_cycles(LAT + 3, ST_RUN);

    // pause then reset-to-idle clears
    btn_ss = 1'b1;
    run_cycles(LAT, ST_RUN);
    step();
    check_st("pause2", state, ST_PAUSE);
    check1("pause2_tick", tick_en, 1'b0);
    btn_ss = 1'b0;
    still_cycles(LAT + 3, ST_PAUSE);
    btn_lr = 1'b1;
    still_cycles(LAT, ST_PAUSE);
    step();
    check_st("clr_state", state, ST_IDLE);
    check1("clr_pulse", cnt_clr, 1'b1);
    btn_lr = 1'b0;
    still_cycles(LAT + 3, ST_IDLE);

    // prescaler was zeroed: first tick exactly TDIV cycles after RUN entry
    btn_ss = 1'b1;
    still_cycles(LAT, ST_IDLE);
    step();
    check_st("rerun", state, ST_RUN);
    btn_ss = 1'b0;
    for (int i = 1; i < TDIV; i++) begin
      step();
      check1("rerun_notick", tick_en, 1'b0);
    end
    step();
    check1("rerun_tick", tick_en, 1'b1);
    ph = 0;
    run_cycles(LAT + 3, ST_RUN);

    // 5. simultaneous ss and lr: ss wins
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    run_cycles(LAT, ST_RUN);
    step();
    check_st("both_state", state, ST_PAUSE);
    check1("both_strobe", lap_strobe, 1'b0);
    check1("both_clr", cnt_clr, 1'b0);
    check1("both_tick", tick_en, 1'b0);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    still_cycles(LAT + 3, ST_PAUSE);
    btn_ss = 1'b1;
    still_cycles(LAT, ST_PAUSE);
    step();
    check_st("both_resume", state, ST_RUN);
    btn_ss = 1'b0;
    run_cycles(5, ST_RUN);

    // reset mid-RUN: IDLE immediately, no clear pulse
    reset = 1'b1;
    #2;
    check_st("async_rst_state", state, ST_IDLE);
    check1("async_rst_run", run, 1'b0);
    check1("async_rst_clr", cnt_clr, 1'b0);
    check1("async_rst_tick", tick_en, 1'b0);
    step();
    reset = 1'b0;
    still_cycles(4, ST_IDLE);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
